// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: datapath widths,
// requester indices and the per-requester writeback request bundle.
package wb_port_arbiter_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Writeback requesters sharing the single regfile write port
    localparam int NUM_WB_REQ = 3;
    localparam int WB_IDX_ALU = 0;
    localparam int WB_IDX_LSU = 1;
    localparam int WB_IDX_MDU = 2;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           data;
    } wb_req_t;

    // Width of an index into n requesters (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr.sv
// Purely combinational round-robin picker: the first asserted request at or
// after ptr, searching upward and wrapping, wins. The pointer register is
// owned by the caller.
module rr_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int N  = NUM_WB_REQ,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] idx;

    // Circular scan from ptr; the first valid index claims the one-hot grant
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the ALU, LSU and MDU writeback
// producers. Grants are round-robin with valid/ready handshakes, the winning
// write is registered for one cycle, and a saturating counter tracks cycles
// in which two or more producers were competing.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_WB_REQ,
    parameter int CNT_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0] req_rd,
    input  logic [NUM_REQ-1:0][XLEN-1:0]           req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic                                   wb_hold,
    output logic                                   wb_wr_en,
    output logic [REG_ADDR_WIDTH-1:0]              wb_rd,
    output logic [XLEN-1:0]                        wb_data,
    output logic [CNT_WIDTH-1:0]                   contention_cnt
);

    localparam int IW = idx_width(NUM_REQ);

    logic [IW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    wb_req_t            reqs [NUM_REQ];
    wb_req_t            win;
    logic               grant_en;
    logic               transfer;
    logic               contended;

    // Pointer advances to the slot just after the requester that was served
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        if (int'(g) == NUM_REQ - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    // Counter sticks at all-ones instead of wrapping
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Bundle each requester's flat port slices into a request record
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i] = '{valid: req_valid[i], rd: req_rd[i], data: req_data[i]};
        end
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are suppressed while held or in reset; a transfer is any accepted grant
    always_comb begin
        grant_en  = !wb_hold && reset_n;
        req_ready = grant & {NUM_REQ{grant_en}};
        win       = reqs[grant_idx];
        transfer  = win.valid && grant_en;
        contended = ($countones(req_valid) >= 2) && !wb_hold;
    end

    // Register the winning write, advance the pointer and count contention
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_wr_en       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            rr_ptr         <= '0;
            contention_cnt <= '0;
        end else begin
            // Writes to x0 are consumed but never reach the regfile
            wb_wr_en <= transfer && (win.rd != '0);
            if (transfer) begin
                wb_rd   <= win.rd;
                wb_data <= win.data;
                rr_ptr  <= next_ptr(grant_idx);
            end
            if (contended) begin
                contention_cnt <= sat_inc(contention_cnt);
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed stimulus with literal expectations plus
// a per-cycle reference model of the round-robin writeback port. A second
// instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic [2:0]                    valid;
    logic [2:0][REG_ADDR_WIDTH-1:0] rd;
    logic [2:0][XLEN-1:0]          data;
    logic                          hold;

    logic [2:0]                    ready,  ready4;
    logic                          wr,     wr4;
    logic [REG_ADDR_WIDTH-1:0]     wrd,    wrd4;
    logic [XLEN-1:0]               wdata,  wdata4;
    logic [31:0]                   cnt;
    logic [3:0]                    cnt4;

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(.NUM_REQ(3), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(valid), .req_rd(rd),
        .req_data(data), .req_ready(ready), .wb_hold(hold), .wb_wr_en(wr),
        .wb_rd(wrd), .wb_data(wdata), .contention_cnt(cnt)
    );

    wb_port_arbiter #(.NUM_REQ(3), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req_valid(valid), .req_rd(rd),
        .req_data(data), .req_ready(ready4), .wb_hold(hold), .wb_wr_en(wr4),
        .wb_rd(wrd4), .wb_data(wdata4), .contention_cnt(cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pending regfile write, round-robin start point, and
    // an unbounded count of contended cycles
    logic                      m_wr;
    logic [REG_ADDR_WIDTH-1:0] m_rd;
    logic [XLEN-1:0]           m_data;
    int                        m_ptr;
    int                        m_cnt;
    int                        w;
    logic [2:0]                er;

    // Index of the first valid requester at or after p, circularly; -1 if none
    function automatic int first_valid(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    // Compare both DUTs against the model each cycle, then advance the model
    always @(negedge clk) begin
        if (!reset_n) begin
            m_wr = 1'b0; m_rd = '0; m_data = '0; m_ptr = 0; m_cnt = 0;
        end
        chk("m_wren", wr, m_wr);
        chk("m_wren4", wr4, m_wr);
        if (m_wr) begin
            chk("m_rd", wrd, m_rd);
            chk("m_data", wdata, m_data);
            chk("m_rd4", wrd4, m_rd);
        end
        chk("m_cnt", cnt, m_cnt);
        chk("m_cnt4", cnt4, (m_cnt > 15) ? 15 : m_cnt);
        w  = first_valid(valid, m_ptr);
        er = (reset_n && !hold && w >= 0) ? (3'b001 << w) : 3'b000;
        chk("m_ready", ready, er);
        chk("m_ready4", ready4, er);
        if (reset_n) begin
            if (er != 3'b000) begin
                m_wr = (rd[w[1:0]] != '0);
                if (m_wr) begin
                    m_rd   = rd[w[1:0]];
                    m_data = data[w[1:0]];
                end
                m_ptr = (w + 1) % 3;
            end else begin
                m_wr = 1'b0;
            end
            if (!hold && $countones(valid) >= 2) m_cnt++;
        end
    end

    logic [2:0] order [6];

    initial begin
        reset_n = 1'b0;
        hold    = 1'b0;
        valid   = 3'b111;
        rd      = {5'd3, 5'd2, 5'd1};
        data    = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};

        // Reset held with every requester valid
        repeat (2) step();
        #1;
        chk("rst_ready", ready, 3'b000);
        chk("rst_wren", wr, 1'b0);
        chk("rst_cnt", cnt, 0);
        chk("rst_cnt4", cnt4, 0);
        step();
        reset_n = 1'b1;
        valid   = 3'b000;

        // Lone ALU write
        step();
        valid = 3'b001; rd[0] = 5'd5; data[0] = 32'hDEADBEEF;
        #1 chk("alu_ready", ready, 3'b001);
        step();
        valid = 3'b000;
        #1;
        chk("alu_wren", wr, 1'b1);
        chk("alu_rd", wrd, 5);
        chk("alu_data", wdata, 32'hDEADBEEF);
        step();
        #1 chk("alu_wren_off", wr, 1'b0);

        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1;

        // All three contending from rr_ptr=0
        order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        step();
        valid = 3'b111;
        rd    = {5'd3, 5'd2, 5'd1};
        data  = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_order", ready, order[k]);
            step();
        end
        valid = 3'b000;
        #1;
        chk("rr_cnt", cnt, 6);
        chk("rr_last_rd", wrd, 3);
        chk("rr_last_wren", wr, 1'b1);

        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1;

        // LSU writing x0 alongside an ALU write to x7
        step();
        valid = 3'b011; rd[0] = 5'd7; rd[1] = 5'd0;
        data[0] = 32'h0000_0077; data[1] = 32'h0000_1111;
        #1 chk("x0_ready_alu", ready, 3'b001);
        step();
        valid = 3'b010;
        #1;
        chk("x0_ready_lsu", ready, 3'b010);
        chk("x0_alu_wren", wr, 1'b1);
        chk("x0_alu_rd", wrd, 7);
        step();
        valid = 3'b011;
        #1;
        chk("x0_suppressed", wr, 1'b0);
        chk("x0_ptr_past_lsu", ready, 3'b001);
        step();
        valid = 3'b000;
        #1 chk("x0_alu_again", wr, 1'b1);

        // Hold with ALU and MDU pending; rr_ptr sits at LSU
        step();
        valid = 3'b101; hold = 1'b1;
        rd[2] = 5'd12; data[2] = 32'h0000_00CC;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready", ready, 3'b000);
            chk("hold_wren", wr, 1'b0);
            if (k < 2) step();
        end
        chk("hold_cnt", cnt, 2);
        step();
        hold = 1'b0;
        #1 chk("hold_resume_mdu", ready, 3'b100);
        step();
        valid = 3'b001;
        #1;
        chk("hold_next_alu", ready, 3'b001);
        chk("hold_mdu_rd", wrd, 12);
        chk("hold_cnt_after", cnt, 3);
        step();
        valid = 3'b000;
        #1 chk("hold_alu_rd", wrd, 7);

        // Sustained contention drives the narrow counter into saturation
        step();
        valid = 3'b111;
        rd    = {5'd3, 5'd2, 5'd1};
        repeat (20) step();
        valid = 3'b000;
        #1;
        chk("sat_cnt4", cnt4, 4'hF);
        chk("sat_cnt32", cnt, 23);

        // Reset mid-stream kills the registered write immediately
        step();
        valid = 3'b001; rd[0] = 5'd9; data[0] = 32'h0000_0099;
        step();
        valid = 3'b000;
        #1 chk("mid_wren_before", wr, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_async_wren", wr, 1'b0);
        chk("mid_async_rd", wrd, 0);
        step();
        reset_n = 1'b1;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
